instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//   Parametrised instruction fetch unit: program counter, instruction register and fetch FSM in one block.
//   Sits between program memory (synchronous RAM of configurable read latency) and the control circuit.
//   Issues fetches, holds the instruction until control asserts done, then advances or branches.
//   Supports external-instruction mode, memory-port stalls and PC wrap-around.
// PARAMETERS
//   INSTR_WIDTH  16  width of instruction word, bus_in and mem_q
//   ADDR_WIDTH   8   width of PC / program address; PC wraps modulo 2^ADDR_WIDTH
//   RAM_LATENCY  1   cycles from mem_rd_en to mem_q valid (1..7)
//   RESET_ADDR   0   PC value after reset and on leaving external mode
// PORTS
//   clk          in   1            rising-edge clock, only clock
//   reset        in   1            asynchronous, active-low reset
//   mode_sel     in   1            1 = instructions from ext_instr, 0 = from program memory
//   ext_instr    in   INSTR_WIDTH  external instruction word
//   ext_valid    in   1            ext_instr valid this cycle (external mode only)
//   mem_busy     in   1            control owns memory port (RAM write); fetch must not issue
//   mem_q        in   INSTR_WIDTH  program memory read data
//   mem_addr     out  ADDR_WIDTH   program memory address (registered)
//   mem_rd_en    out  1            one-cycle read strobe
//   done         in   1            control finished current instruction
//   pc_load      in   1            with done: branch, next PC = bus_in[ADDR_WIDTH-1:0]
//   bus_in       in   INSTR_WIDTH  data bus value for branch target
//   instr        out  INSTR_WIDTH  instruction register
//   instr_valid  out  1            instr holds an instruction awaiting done
//   pc           out  ADDR_WIDTH   address of instruction in instr (or being fetched)
// BEHAVIOUR
//   Reset (reset=0, async): pc=RESET_ADDR, mem_addr=RESET_ADDR, instr=0, instr_valid=0,
//     mem_rd_en=0, wait counter=0, state=IDLE. First state change on first clk edge after release.
//   States: IDLE, FETCH, WAIT, HOLD, EXT.
//   IDLE: next = EXT if mode_sel else FETCH.
//   FETCH: if mem_busy -> stay, mem_rd_en=0. Else mem_addr=pc, mem_rd_en=1 for exactly one cycle,
//     counter loaded with RAM_LATENCY, -> WAIT.
//   WAIT: counter decrements each cycle; at 0 instr<=mem_q, instr_valid<=1, -> HOLD.
//     Fetch latency: rd_en cycle to instr_valid high = RAM_LATENCY+1 cycles.
//     mem_busy ignored in WAIT (read already issued).
//   HOLD: instr, instr_valid stable until done=1. On done: instr_valid<=0;
//     pc <= pc_load ? bus_in[ADDR_WIDTH-1:0] : pc+1 (wraps 2^ADDR_WIDTH-1 -> 0);
//     next = EXT if mode_sel else FETCH. pc_load without done ignored.
//   EXT: pc held. If ext_valid and !instr_valid: instr<=ext_instr, instr_valid<=1.
//     On done: instr_valid<=0; same cycle ext_valid does not load (one-cycle bubble).
//     If mode_sel=0 at a boundary (instr_valid=0): pc<=RESET_ADDR, -> FETCH.
//   mode_sel sampled only at instruction boundaries; change while instr_valid=1 has no effect
//     until done.
//   done while instr_valid=0 ignored in all states. mem_rd_en never asserted outside FETCH.
//   Reset mid-fetch: outstanding read discarded; mem_q ignored until next FETCH.
//   Upper bus_in bits above ADDR_WIDTH discarded, no error.
// TESTING
//   1. Reset, mode_sel=0, RAM_LATENCY=1, mem[0]=16'h1234: rd_en at cycle 1 addr 0,
//      instr_valid=1 instr=16'h1234 at cycle 3; held 5 cycles with done=0.
//   2. done pulse, pc_load=0 -> next fetch addr 1; repeat to pc=8'hFF, done -> fetch addr 8'h00.
//   3. done with pc_load=1, bus_in=16'hAB42 -> next fetch addr 8'h42, pc=8'h42.
//   4. mem_busy=1 for 3 cycles while in FETCH -> mem_rd_en low those cycles, read issues cycle after
//      release; RAM_LATENCY=3 build: instr_valid exactly 4 cycles after rd_en.
//   5. mode_sel=1, ext_valid with 16'hBEEF -> instr=16'hBEEF, no rd_en; done then mode_sel=0
//      -> pc=RESET_ADDR, fetch addr 0.
//   6. reset low during WAIT -> all outputs to reset values asynchronously; stale mem_q never
//      reaches instr.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: program counter, instruction register and fetch FSM.
// Fetches from a fixed-latency synchronous program RAM, or takes words from an external source.
module instr_fetch_unit #(
  parameter int unsigned           INSTR_WIDTH = 16,
  parameter int unsigned           ADDR_WIDTH  = 8,
  parameter int unsigned           RAM_LATENCY = 1,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mode_sel,
  input  logic [INSTR_WIDTH-1:0] ext_instr,
  input  logic                   ext_valid,
  input  logic                   mem_busy,
  input  logic [INSTR_WIDTH-1:0] mem_q,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic                   mem_rd_en,
  input  logic                   done,
  input  logic                   pc_load,
  input  logic [INSTR_WIDTH-1:0] bus_in,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid,
  output logic [ADDR_WIDTH-1:0]  pc
);

  localparam int unsigned CntW = 3;

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StHold, StExt} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic                   mem_rd_en_q, mem_rd_en_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   instr_valid_q, instr_valid_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  // Only the low ADDR_WIDTH bits of bus_in form a branch target.
  logic unused_bus_in;
  assign unused_bus_in = ^bus_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      pc_q          <= RESET_ADDR;
      mem_addr_q    <= RESET_ADDR;
      mem_rd_en_q   <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      mem_addr_q    <= mem_addr_d;
      mem_rd_en_q   <= mem_rd_en_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    mem_addr_d    = mem_addr_q;
    mem_rd_en_d   = 1'b0;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    cnt_d         = cnt_q;

    unique case (state_q)
      StIdle: state_d = mode_sel ? StExt : StFetch;

      StFetch: begin
        if (!mem_busy) begin
          mem_addr_d  = pc_q;
          mem_rd_en_d = 1'b1;
          cnt_d       = CntW'(RAM_LATENCY);
          state_d     = StWait;
        end
      end

      // Counting down to zero lands the capture exactly RAM_LATENCY cycles after the strobe.
      StWait: begin
        if (cnt_q == '0) begin
          instr_d       = mem_q;
          instr_valid_d = 1'b1;
          state_d       = StHold;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StHold: begin
        if (done && instr_valid_q) begin
          instr_valid_d = 1'b0;
          pc_d          = pc_load ? bus_in[ADDR_WIDTH-1:0] : pc_q + ADDR_WIDTH'(1);
          state_d       = mode_sel ? StExt : StFetch;
        end
      end

      // A done cycle only clears valid, so ext_valid cannot load until the following cycle.
      StExt: begin
        if (instr_valid_q) begin
          if (done) instr_valid_d = 1'b0;
        end else if (!mode_sel) begin
          pc_d    = RESET_ADDR;
          state_d = StFetch;
        end else if (ext_valid) begin
          instr_d       = ext_instr;
          instr_valid_d = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign mem_addr    = mem_addr_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;

endmodule
